// File: rtl/uart_count_reporter.sv
// Formats a 14-bit count as four ASCII decimal digits plus CR LF and streams the
// bytes through a start/done UART TX handshake, on request or on a periodic tick.
module uart_count_reporter #(
  parameter bit AUTO_EN    = 1'b0,
  parameter int PERIOD_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_digit,
  input  logic        i_send,
  input  logic        i_tx_done,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_busy
);

  localparam int CW = $clog2(PERIOD_CYC);

  typedef enum logic [2:0] {IDLE, CONV, LOAD, START, WAIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] period_cnt;
  logic          auto_tick;
  logic          trigger;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [3:0]    step;
  logic [2:0]    idx;
  logic [7:0]    byte_sel;
  logic [7:0]    tx_data;
  logic          busy;

  assign auto_tick = AUTO_EN && (period_cnt == CW'(PERIOD_CYC - 1));
  assign trigger   = i_send | auto_tick;

  // Free-running interval counter; keeps counting while a message is in flight.
  always_ff @(posedge clk) begin
    if (reset || !AUTO_EN) begin
      period_cnt <= '0;
    end else if (period_cnt == CW'(PERIOD_CYC - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Double-dabble add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    byte_sel = 8'h0A;
    case (idx)
      3'd0:    byte_sel = 8'h30 + {4'h0, bcd[15:12]};
      3'd1:    byte_sel = 8'h30 + {4'h0, bcd[11:8]};
      3'd2:    byte_sel = 8'h30 + {4'h0, bcd[7:4]};
      3'd3:    byte_sel = 8'h30 + {4'h0, bcd[3:0]};
      3'd4:    byte_sel = 8'h0D;
      default: byte_sel = 8'h0A;
    endcase
  end

  always_comb begin
    state_nx   = state;
    o_tx_start = 1'b0;
    case (state)
      IDLE:  if (trigger) state_nx = CONV;
      CONV:  if (step == 4'd13) state_nx = LOAD;
      LOAD:  state_nx = START;
      START: begin
        o_tx_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT:  if (i_tx_done) state_nx = (idx == 3'd5) ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bin     <= '0;
      bcd     <= '0;
      step    <= '0;
      idx     <= '0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (trigger) begin
          bin  <= (i_digit > 14'd9999) ? 14'd9999 : i_digit;
          bcd  <= '0;
          step <= '0;
          idx  <= '0;
          busy <= 1'b1;
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
          step       <= step + 4'd1;
        end
        LOAD: tx_data <= byte_sel;
        WAIT: if (i_tx_done) begin
          if (idx == 3'd5) begin
            idx  <= '0;
            busy <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data = tx_data;
  assign o_busy    = busy;

endmodule
